// File: rtl/gpu_task_dispatcher_if.sv
// Message channel from the task dispatcher to the core array: one typed word per
// valid/ready transfer.
interface gpu_task_dispatcher_if #(
  parameter int INSTR_SIZE = 16
) ();
  logic [INSTR_SIZE-1:0] msg_data;
  logic [1:0]            msg_kind;
  logic                  msg_valid;
  logic                  msg_ready;

  modport master (output msg_data, msg_kind, msg_valid, input msg_ready);
  modport slave  (input msg_data, msg_kind, msg_valid, output msg_ready);
endinterface

// File: rtl/gpu_task_dispatcher.sv
// Streams task frames from a local program memory to the cores as typed message words,
// gating each task on core availability and on acquire/release fences.
module gpu_task_dispatcher #(
  parameter int INSTR_SIZE = 16,
  parameter int CORE_NUM   = 16,
  parameter int FRAME_SIZE = 16,
  parameter int PROG_DEPTH = 1024,
  parameter int IFNUM_W    = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          prog_we_i,
  input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr_i,
  input  logic [INSTR_SIZE-1:0]         prog_wdata_i,
  input  logic                          start_i,
  input  logic [CORE_NUM-1:0]           core_busy_i,
  gpu_task_dispatcher_if.master         msg,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o
);
  localparam int AW = $clog2(PROG_DEPTH);
  localparam int TW = AW + 1;
  localparam int FW = $clog2(FRAME_SIZE);
  localparam int CW = IFNUM_W + FW + 1;

  localparam logic [1:0] FENCE_ACQ   = 2'd1;
  localparam logic [1:0] FENCE_REL   = 2'd2;
  localparam logic [1:0] KIND_CMASK  = 2'd0;
  localparam logic [1:0] KIND_R0MASK = 2'd1;
  localparam logic [1:0] KIND_R0DATA = 2'd2;
  localparam logic [1:0] KIND_INSTR  = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_GATE, S_MASK, S_R0M, S_R0D, S_INSTR, S_ACQ_WAIT, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         tp_q, tp_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IFNUM_W-1:0]    if_num_q, if_num_d;
  logic [1:0]            fence_q, fence_d;
  logic [CORE_NUM-1:0]   core_mask_q, core_mask_d;
  logic [INSTR_SIZE-1:0] r0m_q, r0m_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [INSTR_SIZE-1:0] mem [PROG_DEPTH];
  logic [AW-1:0]         rd_addr;
  logic                  cores_free;
  logic                  msg_valid;
  logic [1:0]            msg_kind;
  logic [INSTR_SIZE-1:0] msg_data;

  assign rd_addr    = tp_q[AW-1:0];
  assign busy_o     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign cores_free = (core_mask_q & core_busy_i) == '0;

  assign msg.msg_valid = msg_valid;
  assign msg.msg_kind  = msg_kind;
  assign msg.msg_data  = msg_data;

  // NOTE: the program store has no reset; its contents are undefined until loaded,
  // and keeping it off the reset net lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (prog_we_i && !busy_o) mem[prog_addr_i] <= prog_wdata_i;
  end

  // NOTE: every state register is assigned with <= so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      tp_q        <= '0;
      cnt_q       <= '0;
      if_num_q    <= '0;
      fence_q     <= '0;
      core_mask_q <= '0;
      r0m_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tp_q        <= tp_d;
      cnt_q       <= cnt_d;
      if_num_q    <= if_num_d;
      fence_q     <= fence_d;
      core_mask_q <= core_mask_d;
      r0m_q       <= r0m_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    tp_d        = tp_q;
    cnt_d       = cnt_q;
    if_num_d    = if_num_q;
    fence_d     = fence_q;
    core_mask_d = core_mask_q;
    r0m_d       = r0m_q;
    done_d      = done_q;
    err_d       = err_q;
    msg_valid   = 1'b0;
    msg_kind    = KIND_CMASK;
    msg_data    = '0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i && !prog_we_i) begin
          tp_d    = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (mem[rd_addr][INSTR_SIZE-1]) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          if_num_d    = mem[rd_addr][IFNUM_W-1:0];
          fence_d     = mem[rd_addr][IFNUM_W+1:IFNUM_W];
          core_mask_d = mem[rd_addr + AW'(1)][CORE_NUM-1:0];
          r0m_d       = mem[rd_addr + AW'(2)];
          tp_d        = tp_q + TW'(1);
          state_d     = S_GATE;
        end
      end
      S_GATE: begin
        if (cores_free && (fence_q != FENCE_REL || core_busy_i == '0)) state_d = S_MASK;
      end
      S_MASK: begin
        msg_valid = 1'b1;
        msg_kind  = KIND_CMASK;
        msg_data  = INSTR_SIZE'(core_mask_q);
        if (msg.msg_ready) begin
          tp_d    = tp_q + TW'(1);
          state_d = S_R0M;
        end
      end
      S_R0M: begin
        msg_valid = 1'b1;
        msg_kind  = KIND_R0MASK;
        msg_data  = r0m_q;
        if (msg.msg_ready) begin
          tp_d    = tp_q + TW'(1);
          cnt_d   = CW'(FRAME_SIZE - 3);
          state_d = S_R0D;
        end
      end
      S_R0D: begin
        msg_valid = 1'b1;
        msg_kind  = KIND_R0DATA;
        msg_data  = mem[rd_addr];
        if (msg.msg_ready) begin
          tp_d  = tp_q + TW'(1);
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            if (if_num_q == '0) begin
              state_d = (fence_q == FENCE_ACQ) ? S_ACQ_WAIT : S_HDR;
            end else begin
              cnt_d   = CW'(if_num_q) << FW;
              state_d = S_INSTR;
            end
          end
        end
      end
      S_INSTR: begin
        msg_valid = 1'b1;
        msg_kind  = KIND_INSTR;
        msg_data  = mem[rd_addr];
        if (msg.msg_ready) begin
          tp_d  = tp_q + TW'(1);
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = (fence_q == FENCE_ACQ) ? S_ACQ_WAIT : S_HDR;
        end
      end
      S_ACQ_WAIT: begin
        if (cores_free) state_d = S_HDR;
      end
      default: state_d = S_IDLE;
    endcase

    // Running off the end of program memory aborts the dispatch instead of wrapping.
    if (busy_o && tp_d == TW'(PROG_DEPTH)) begin
      done_d  = 1'b1;
      err_d   = 1'b1;
      state_d = S_DONE;
    end
  end
endmodule

// File: doc/gpu_task_dispatcher.md
GPU_TASK_DISPATCHER -- requirements
Module: gpu_task_dispatcher

Interface
REQ-001 SHALL provide parameter INSTR_SIZE, default 16, message/program word width in bits.
REQ-002 SHALL provide parameter CORE_NUM, default 16, number of cores; 1..INSTR_SIZE.
REQ-003 SHALL provide parameter FRAME_SIZE, default 16, words per frame; power of two, >= 4.
REQ-004 SHALL provide parameter PROG_DEPTH, default 1024, program memory words; multiple of FRAME_SIZE.
REQ-005 SHALL provide parameter IFNUM_W, default 6, width of the instruction-frame count field.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 prog_we  input  1  program memory write strobe.
REQ-009 prog_addr  input  log2(PROG_DEPTH)  program write address.
REQ-010 prog_wdata  input  INSTR_SIZE  program write data.
REQ-011 start  input  1  single-cycle pulse; begins dispatch from address 0.
REQ-012 core_busy  input  CORE_NUM  bit i high = core i executing.
REQ-013 msg_data  output  INSTR_SIZE  message word to cores.
REQ-014 msg_kind  output  2  0 core mask, 1 r0 mask, 2 r0 data, 3 instruction.
REQ-015 msg_valid  output  1  msg_data/msg_kind valid.
REQ-016 msg_ready  input  1  cores accept current word.
REQ-017 busy  output  1  dispatch in progress.
REQ-018 done  output  1  sticky completion flag.
REQ-019 err  output  1  sticky overrun error flag.

Function
REQ-020 Task layout at frame base B: word B+0 header (bits [IFNUM_W-1:0] if_num, [IFNUM_W+1:IFNUM_W] fence: 0 none, 1 acquire, 2 release, 3 treated as none; bit INSTR_SIZE-1 end marker), B+1 core mask, B+2 r0 mask, B+3..B+FRAME_SIZE-1 r0 data, then if_num instruction frames of FRAME_SIZE words each.
REQ-021 States: IDLE, HDR, GATE, MASK, R0M, R0D, INSTR, ACQ_WAIT, DONE.
REQ-022 IDLE: on start with prog_we low, pointer tp := 0, clear done/err, go HDR; start while prog_we high or while busy SHALL be ignored.
REQ-023 prog_we SHALL write memory only when not busy; writes while busy are dropped.
REQ-024 HDR (1 cycle): latch header, core mask (low CORE_NUM bits of word B+1), r0 mask; end marker set -> DONE, else GATE.
REQ-025 GATE: advance to MASK only when (core_mask & core_busy)==0 and (fence!=release or core_busy==0); otherwise hold with msg_valid low.
REQ-026 MASK, R0M, R0D, INSTR: msg_valid high; msg_data/msg_kind stable until transfer (msg_valid & msg_ready); each transfer advances tp by 1.
REQ-027 MASK sends latched core mask (kind 0); R0M sends r0 mask (kind 1); R0D sends FRAME_SIZE-3 words (kind 2); INSTR sends if_num*FRAME_SIZE words (kind 3); if_num==0 skips INSTR.
REQ-028 msg_valid SHALL deassert the cycle after the final transfer of a task; no bubble between consecutive words of a task while msg_ready is high (1 word per cycle).
REQ-029 After last word: fence==acquire -> ACQ_WAIT until (core_mask & core_busy)==0, then HDR; else HDR directly at next frame base.
REQ-030 If tp would reach PROG_DEPTH before an end marker, set err and done, go DONE; no wrap-around.
REQ-031 DONE: busy low, done high, msg_valid low; on start re-enter as IDLE rule (REQ-022).
REQ-032 busy SHALL be high in every state except IDLE and DONE.

Reset
REQ-033 reset low SHALL immediately (asynchronously) set state IDLE, tp 0, msg_valid 0, msg_data 0, msg_kind 0, busy 0, done 0, err 0; memory contents undefined.
REQ-034 reset assertion mid-transfer SHALL abort the task with no further messages; release needs a new start.

Verification
REQ-035 Task {hdr if_num=1 fence=0, mask 0x0003, r0m 0x0001, r0 data}, then end marker, msg_ready=1, core_busy=0 -> 2+13+16=31 transfers kinds 0,1,2x13,3x16, then done=1, err=0.
REQ-036 Same program, msg_ready toggling 1/0 -> identical word sequence, each word held stable while msg_ready=0.
REQ-037 core_busy=0x0002 with task mask 0x0003 -> msg_valid stays 0 until core_busy=0, first word 0x0003 the following cycles.
REQ-038 Task1 fence=acquire mask 0x000F, core_busy=0x0001 after its last word -> no HDR message until core_busy=0; fence=release task with core_busy=0x8000 blocks likewise.
REQ-039 Program with no end marker -> err=1, done=1 after PROG_DEPTH words consumed.
REQ-040 reset low mid-INSTR -> msg_valid=0 same cycle, busy=0; prog_we during busy leaves memory unchanged.
